line_fill_engine: RTL and testbench

LINE_FILL_ENGINE -- requirements
Module: line_fill_engine

---
 rtl/line_fill_engine.sv | 110 +++++++++++
 tb/tb_line_fill_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_engine.sv
// Cache line fill engine: optional dirty-victim writeback to memory, then a
// line_words-word read burst whose returns stream straight into the cache line.
module line_fill_engine #(
    parameter int mem_depth  = 32,
    parameter int data_width = 32,
    parameter int line_words = 4,
    localparam int AW = $clog2(mem_depth),
    localparam int IW = $clog2(line_words)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_fill_addr,
    input  logic                  req_wb,
    input  logic [AW-1:0]         req_wb_addr,
    output logic [IW-1:0]         wb_idx,
    input  logic [data_width-1:0] wb_rdata,
    output logic                  fill_we,
    output logic [IW-1:0]         fill_idx,
    output logic [data_width-1:0] fill_data,
    output logic                  done,
    output logic [AW-1:0]         fetch_mem_raddr,
    output logic                  fetch_mem_ren,
    input  logic                  fetch_mem_rready,
    input  logic [data_width-1:0] fetch_mem_rdata,
    input  logic                  fetch_mem_rdata_valid,
    output logic [AW-1:0]         fetch_mem_waddr,
    output logic                  fetch_mem_wen,
    input  logic                  fetch_mem_wready,
    output logic [data_width-1:0] fetch_mem_wdata
);

    typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(line_words - 1);
    localparam logic [IW:0]   LINE_CNT   = (IW+1)'(line_words);
    localparam logic [IW:0]   LAST_CNT   = (IW+1)'(line_words - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(line_words - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] wb_base, fill_base;
    // One bit wider than an index so "all issued" is representable.
    logic [IW:0]   rd_issued, rd_ret;

    assign fetch_mem_waddr = wb_base + AW'(wb_idx);
    assign fetch_mem_wdata = wb_rdata;
    assign fetch_mem_raddr = fill_base + AW'(rd_issued);
    assign fill_data       = fetch_mem_rdata;
    assign fill_idx        = rd_ret[IW-1:0];

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        fetch_mem_wen = 1'b0;
        fetch_mem_ren = 1'b0;
        fill_we       = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_wb ? WB : RD;
            end
            WB: begin
                fetch_mem_wen = 1'b1;
                if (fetch_mem_wready && wb_idx == LAST_IDX) state_nxt = RD;
            end
            RD: begin
                fetch_mem_ren = (rd_issued < LINE_CNT);
                fill_we       = fetch_mem_rdata_valid;
                if (fetch_mem_rdata_valid && rd_ret == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wb_base   <= '0;
            fill_base <= '0;
            wb_idx    <= '0;
            rd_issued <= '0;
            rd_ret    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    wb_base   <= req_wb_addr & ALIGN_MASK;
                    fill_base <= req_fill_addr & ALIGN_MASK;
                    wb_idx    <= '0;
                    rd_issued <= '0;
                    rd_ret    <= '0;
                end
                // wb_idx wraps back to 0 on the last accepted write.
                WB: if (fetch_mem_wready) wb_idx <= wb_idx + IW'(1);
                RD: begin
                    if (fetch_mem_ren && fetch_mem_rready) rd_issued <= rd_issued + (IW+1)'(1);
                    if (fetch_mem_rdata_valid) rd_ret <= rd_ret + (IW+1)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine: cycle-by-cycle vector table plus
// hand-written reset, busy and write-stall sequences against a one-cycle memory.
module tb_line_fill_engine;

    localparam int AW = 5;
    localparam int IW = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_wb;
    logic [AW-1:0] req_fill_addr, req_wb_addr;
    logic [IW-1:0] wb_idx, fill_idx;
    logic [31:0]   wb_rdata, fill_data;
    logic          fill_we, done;
    logic [AW-1:0] fetch_mem_raddr, fetch_mem_waddr;
    logic          fetch_mem_ren, fetch_mem_rready, fetch_mem_rdata_valid;
    logic [31:0]   fetch_mem_rdata, fetch_mem_wdata;
    logic          fetch_mem_wen, fetch_mem_wready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    line_fill_engine #(.mem_depth(32), .data_width(32), .line_words(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fill_addr(req_fill_addr), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
        .wb_idx(wb_idx), .wb_rdata(wb_rdata),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .done(done),
        .fetch_mem_raddr(fetch_mem_raddr), .fetch_mem_ren(fetch_mem_ren),
        .fetch_mem_rready(fetch_mem_rready),
        .fetch_mem_rdata(fetch_mem_rdata), .fetch_mem_rdata_valid(fetch_mem_rdata_valid),
        .fetch_mem_waddr(fetch_mem_waddr), .fetch_mem_wen(fetch_mem_wen),
        .fetch_mem_wready(fetch_mem_wready), .fetch_mem_wdata(fetch_mem_wdata)
    );

    // Victim line words and memory contents carry their index/address in the low byte.
    assign wb_rdata = 32'hC3C3_C3C0 + 32'(wb_idx);

    always @(posedge clk) begin
        fetch_mem_rdata_valid <= fetch_mem_ren && fetch_mem_rready;
        fetch_mem_rdata       <= 32'hA5A5_A500 | 32'(fetch_mem_raddr);
    end

    always @(negedge clk)
        if (fetch_mem_ren && fetch_mem_wen) begin
            errors++;
            $display("FAIL ren_wen_overlap: both strobes high at %0t", $time);
        end

    typedef struct packed {
        logic          rdy, ren;
        logic [AW-1:0] ra;
        logic          wen;
        logic [AW-1:0] wa;
        logic [IW-1:0] wbi;
        logic          fwe;
        logic [IW-1:0] fi;
        logic [31:0]   fd, wd;
        logic          done;
    } outs_t;

    typedef struct {
        logic          rv;
        logic [AW-1:0] fa;
        logic          wb;
        logic [AW-1:0] wa;
        logic          rr;
        outs_t         e;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic void add(input logic rv, input logic [AW-1:0] fa, input logic wb,
                                input logic [AW-1:0] wa, input logic rr,
                                input logic rdy, input logic ren, input logic [AW-1:0] ra,
                                input logic wen, input logic [AW-1:0] wao, input logic [IW-1:0] wbi,
                                input logic fwe, input logic [IW-1:0] fi, input logic [7:0] fd,
                                input logic [7:0] wd, input logic dn);
        vec_t v;
        v.rv = rv; v.fa = fa; v.wb = wb; v.wa = wa; v.rr = rr;
        v.e.rdy = rdy; v.e.ren = ren; v.e.ra = ra; v.e.wen = wen; v.e.wa = wao;
        v.e.wbi = wbi; v.e.fwe = fwe; v.e.fi = fi;
        v.e.fd = {24'hA5A5A5, fd}; v.e.wd = {24'hC3C3C3, wd}; v.e.done = dn;
        vq.push_back(v);
    endfunction

    // Writeback phase rows: four accepted writes from an aligned base.
    function automatic void wb_rows(input int base);
        for (int k = 0; k < LW; k++)
            add(0, 0, 0, 0, 1, 0, 0, 0, 1, AW'(base + k), IW'(k), 0, 0, 0, 8'(8'hC0 + k), 0);
    endfunction

    // Unstalled read phase: issues k=0..3, returns trail by one, then DONE and IDLE.
    function automatic void rd_rows(input int base);
        for (int k = 0; k <= LW; k++)
            add(0, 0, 0, 0, 1, 0, k < LW, AW'(base + k), 0, 0, 0,
                k > 0, IW'(k - 1), 8'(base + k - 1), 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input vec_t v, input int n);
        outs_t g, e;
        @(posedge clk); #1;
        req_valid = v.rv; req_fill_addr = v.fa; req_wb = v.wb; req_wb_addr = v.wa;
        fetch_mem_rready = v.rr; fetch_mem_wready = 1'b1;
        @(negedge clk);
        g = '{req_ready, fetch_mem_ren, fetch_mem_raddr, fetch_mem_wen, fetch_mem_waddr,
              wb_idx, fill_we, fill_idx, fill_data, fetch_mem_wdata, done};
        e = v.e;
        if (!e.ren) begin g.ra = '0; e.ra = '0; end
        if (!e.wen) begin g.wa = '0; e.wa = '0; g.wd = '0; e.wd = '0; end
        if (!e.fwe) begin g.fi = '0; e.fi = '0; g.fd = '0; e.fd = '0; end
        chk($sformatf("vec%0d", n), 128'(g), 128'(e));
    endtask

    // Runs one operation to completion with its own address/latency model.
    task automatic op(input logic [AW-1:0] fa, input logic wb, input logic [AW-1:0] wa,
                      input bit hold, input int wstall, input int exp_lat, input string nm);
        int acc = 0, dn = 0, lat = -1, nw = 0, nr = 0, nf = 0;
        logic [AW-1:0] fb, wbb;
        fb  = fa & ~AW'(LW - 1);
        wbb = wa & ~AW'(LW - 1);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            req_valid = (c == 0) || (hold && c <= exp_lat);
            req_fill_addr = fa; req_wb = wb; req_wb_addr = wa;
            fetch_mem_rready = 1'b1;
            fetch_mem_wready = (c != wstall);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            if (fetch_mem_wen && fetch_mem_wready) begin
                chk({nm, "_waddr"}, 128'(fetch_mem_waddr), 128'(AW'(wbb + nw)));
                nw++;
            end
            if (fetch_mem_ren && fetch_mem_rready) begin
                if (wb && nw != LW) chk({nm, "_rd_before_wb"}, 128'(nw), 128'(LW));
                chk({nm, "_raddr"}, 128'(fetch_mem_raddr), 128'(AW'(fb + nr)));
                nr++;
            end
            if (fill_we) begin
                chk({nm, "_fill"}, 128'({fill_idx, fill_data}),
                    128'({IW'(nf), 32'hA5A5_A500 | 32'(AW'(fb + nf))}));
                nf++;
            end
            if (done) begin dn++; if (lat < 0) lat = c; end
        end
        req_valid = 1'b0;
        fetch_mem_wready = 1'b1;
        chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, "_accepts"}, 128'(acc), 128'(1));
        chk({nm, "_dones"}, 128'(dn), 128'(1));
        chk({nm, "_fills"}, 128'(nf), 128'(LW));
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0;
        req_fill_addr = '0; req_wb_addr = '0;
        fetch_mem_rready = 1'b1; fetch_mem_wready = 1'b1;

        // Fill-only at 8, wb 20 + fill 4, misaligned 30/13, read stall at raddr 6.
        add(1, 8, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd_rows(8);
        add(1, 4, 1, 20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_rows(20); rd_rows(4);
        add(1, 13, 1, 30, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_rows(28); rd_rows(12);
        add(1, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 5, 0, 0, 0, 1, 0, 4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1, 1, 5, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 7, 0, 0, 0, 1, 2, 6, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 7, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(req_ready), 128'(1));
        chk("rst_strobes", 128'({fetch_mem_ren, fetch_mem_wen, fill_we, done}), 128'(0));
        chk("rst_wb_idx", 128'(wb_idx), 128'(0));
        chk("rst_addrs", 128'({fetch_mem_raddr, fetch_mem_waddr}), 128'(0));

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Reset during WB after two accepted writes.
        @(posedge clk); #1 req_valid = 1; req_wb = 1; req_wb_addr = 16; req_fill_addr = 0;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("wbrst_before", 128'({fetch_mem_wen, wb_idx, fetch_mem_waddr}), 128'({1'b1, 2'd2, 5'd18}));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("wbrst_after", 128'({fetch_mem_wen, req_ready, wb_idx, done}), 128'({1'b0, 1'b1, 2'd0, 1'b0}));
        dn = 0;
        for (int c = 0; c < 8; c++) begin @(posedge clk); @(negedge clk); if (done) dn++; end
        chk("wbrst_no_done", 128'(dn), 128'(0));
        op(0, 1, 16, 0, -1, 10, "post_wbrst");

        // Reset during RD: the in-flight return that follows must be dropped.
        @(posedge clk); #1 req_valid = 1; req_wb = 0; req_fill_addr = 8;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdrst_ignored", 128'({fill_we, req_ready, done, fetch_mem_ren}), 128'({1'b0, 1'b1, 1'b0, 1'b0}));
        op(24, 0, 0, 0, -1, 6, "post_rdrst");

        op(20, 0, 0, 1, -1, 6, "busy_fill");
        op(9, 1, 3, 1, -1, 10, "busy_wb");
        op(4, 1, 8, 0, 2, 11, "wstall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
